// File: rtl/mult_share_arbiter_if.sv
// Bus bundle between the multiply-share arbiter,
// its two requesters and the shared multiplier.
interface mult_share_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_ready;
  logic             req0_done;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_ready;
  logic             req1_done;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             busy;
  logic [WIDTH-1:0] mult_in1;
  logic [WIDTH-1:0] mult_in2;
  logic             mult_start;
  logic [WIDTH-1:0] mult_out;
  logic             mult_finish;

  modport slave (
    input  req0_valid,
    input  req0_a,
    input  req0_b,
    output req0_ready,
    output req0_done,
    input  req1_valid,
    input  req1_a,
    input  req1_b,
    output req1_ready,
    output req1_done,
    output result,
    output err,
    output busy,
    output mult_in1,
    output mult_in2,
    output mult_start,
    input  mult_out,
    input  mult_finish
  );

  modport master (
    output req0_valid,
    output req0_a,
    output req0_b,
    input  req0_ready,
    input  req0_done,
    output req1_valid,
    output req1_a,
    output req1_b,
    input  req1_ready,
    input  req1_done,
    input  result,
    input  err,
    input  busy,
    input  mult_in1,
    input  mult_in2,
    input  mult_start,
    output mult_out,
    output mult_finish
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one multiplier between two
// requesters, with a watchdog for a hung multiplier.
module mult_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input logic                clk,
  input logic                RST,
  mult_share_arbiter_if.slave bus
);

  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WDOG = (TIMEOUT != 0);
  localparam logic [TW-1:0] TLAST =
    TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_RECOVER
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic [1:0]       rdy_q, rdy_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             gnt;
  logic             tmo;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    rdy_d   = 2'b00;
    done_d  = 2'b00;
    // On a tie the requester not served last wins
    gnt = (bus.req0_valid && bus.req1_valid)
        ? ~last_q : bus.req1_valid;
    tmo = WDOG && (timer_q == TLAST);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          owner_d = gnt;
          in1_d   = gnt ? bus.req1_a : bus.req0_a;
          in2_d   = gnt ? bus.req1_b : bus.req0_b;
          start_d = 1'b1;
          rdy_d   = gnt ? 2'b10 : 2'b01;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mult_finish) begin
          res_d   = bus.mult_out;
          err_d   = 1'b0;
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = S_RESP;
        end else if (tmo) begin
          res_d   = '0;
          err_d   = 1'b1;
          done_d  = owner_q ? 2'b10 : 2'b01;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RESP: begin
        last_d  = owner_q;
        timer_d = '0;
        err_d   = 1'b0;
        state_d = err_q ? S_RECOVER : S_IDLE;
      end
      S_RECOVER: begin
        // Late product of the aborted op is dropped
        if (bus.mult_finish || tmo) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      timer_q <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      rdy_q   <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.req0_ready = rdy_q[0];
  assign bus.req1_ready = rdy_q[1];
  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.result     = res_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.mult_in1   = in1_q;
  assign bus.mult_in2   = in2_q;
  assign bus.mult_start = start_q;

endmodule
